// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared operand width and FSM state encodings for the EX-stage divider.
package ex_div_ctrl_pkg;
    localparam int WORD_BUS = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ZERO = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/ex_div_ctrl_step.sv
// ex_div_ctrl_step: one combinational restoring-division step (shift in a dividend bit, trial subtract).
module ex_div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_prem,
    output logic             o_qbit
);
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    always_comb begin
        w_shift = {i_prem, i_bit};
        w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};
        o_qbit  = w_shift >= {2'b0, i_divisor};
        o_prem  = o_qbit ? w_diff : w_shift[WIDTH:0];
    end
endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle DIV/DIVU controller; stalls the pipeline during a 32-step restoring divide
// and returns a sign-corrected quotient/remainder with a one-cycle valid strobe.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int WIDTH = WORD_BUS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signed_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_annul,
    output logic             o_stall_req,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dbz;
    logic             w_accept;
    logic             w_qbit;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic [WIDTH:0]   w_prem;
    logic [WIDTH-1:0] w_quo;

    assign w_dvd_neg      = i_signed_op & i_dividend[WIDTH-1];
    assign w_dvs_neg      = i_signed_op & i_divisor[WIDTH-1];
    assign w_dvs_zero     = i_divisor == '0;
    assign w_accept       = i_start & ~i_annul & (r_state == S_IDLE | r_state == S_DONE);
    assign w_quo          = {r_dvd[WIDTH-2:0], w_qbit};
    assign o_stall_req    = r_state == S_BUSY | r_state == S_ZERO | w_accept;
    assign o_result_valid = r_state == S_DONE;
    assign o_quotient     = r_q;
    assign o_remainder    = r_r;
    assign o_div_by_zero  = r_dbz;

    // r_dvd doubles as the dividend shifter and the quotient accumulator
    ex_div_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (i_annul) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_state <= w_dvs_zero ? S_ZERO : S_BUSY;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= (w_dvd_neg & ~w_dvs_zero) ? -i_dividend : i_dividend;
            r_dvs   <= w_dvs_neg ? -i_divisor : i_divisor;
            r_qsign <= w_dvd_neg ^ w_dvs_neg;
            r_rsign <= w_dvd_neg;
        end else if (r_state == S_ZERO) begin
            r_state <= S_DONE;
            r_q     <= '0;
            r_r     <= r_dvd;
            r_dbz   <= 1'b1;
        end else if (r_state == S_BUSY) begin
            r_prem <= w_prem;
            r_dvd  <= w_quo;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_state <= S_DONE;
                r_q     <= r_qsign ? -w_quo : w_quo;
                r_r     <= r_rsign ? -w_prem[WIDTH-1:0] : w_prem[WIDTH-1:0];
                r_dbz   <= 1'b0;
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed and randomized checks of ex_div_ctrl against a cycle-count/arithmetic model.
module tb_ex_div_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sop = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] dvd = '0;
    logic [31:0] dvs = '0;
    logic        stall, valid, dbz;
    logic [31:0] q, r;

    int          n_cmp = 0;
    int          n_bad = 0;

    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    bit          m_z = 1'b0, p_z = 1'b0;

    always #5 clk = ~clk;

    ex_div_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_signed_op    (sop),
        .i_dividend     (dvd),
        .i_divisor      (dvs),
        .i_annul        (annul),
        .o_stall_req    (stall),
        .o_result_valid (valid),
        .o_quotient     (q),
        .o_remainder    (r),
        .o_div_by_zero  (dbz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division as DIV/DIVU define it; 64-bit math makes the overflow case wrap naturally.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rq, output logic [31:0] rr, output bit rz);
        longint sa, sb;
        if (b == 0) begin
            rq = '0; rr = a; rz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            rq = 32'(sa / sb);
            rr = 32'(sa % sb);
            rz = 1'b0;
        end else begin
            rq = a / b; rr = a % b; rz = 1'b0;
        end
    endfunction

    // m_left = cycles remaining until the result cycle; 0 means free to accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
        end else if (annul) begin
            m_left = 0; m_done = 1'b0;
        end else if (start && m_left == 0) begin
            ref_div(sop, dvd, dvs, p_q, p_r, p_z);
            m_left = (dvs == 0) ? 1 : 32;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) begin
                m_q = p_q; m_r = p_r; m_z = p_z;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("stall", 32'(stall), 32'(m_left > 0 || (start && !annul && m_left == 0)));
        check("valid", 32'(valid), 32'(m_done));
        check("quotient", q, m_q);
        check("remainder", r, m_r);
        check("divbyzero", 32'(dbz), 32'(m_z));
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; sop = s; dvd = a; dvs = b;
        #1 check("issue_stall", 32'(stall), 32'd1);
    endtask

    task automatic wait_res(input string name, input int lat, input logic [31:0] eq,
                            input logic [31:0] er, input bit ez, input int inject);
        int n = 1;
        @(posedge clk); #1 start = 1'b0;
        while (!valid && n < 100) begin
            if (n == inject) begin
                start = 1'b1; dvd = 32'h55; dvs = 32'h0;
            end
            @(posedge clk); #1 start = 1'b0;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
        check({name, "_dbz"}, 32'(dbz), 32'(ez));
        check({name, "_stall_done"}, 32'(stall), 32'd0);
    endtask

    initial begin
        bit seen;
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 32'd100, 32'd7);
        wait_res("divu_100_7", 33, 32'd14, 32'd2, 1'b0, 0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("b2b_in_done", 32'(valid), 32'd1);
        wait_res("div_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_res("div_7_m2_ignore", 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 5);
        issue(1'b0, 32'h1234, 32'd0);
        wait_res("divzero", 2, 32'd0, 32'h1234, 1'b1, 0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_res("ovf", 33, 32'h8000_0000, 32'd0, 1'b0, 0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_res("divu_max_1", 33, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);

        @(posedge clk); #1;
        issue(1'b0, 32'd1000, 32'd3);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1 annul = 1'b0;
        check("annul_stall", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1 seen |= valid;
        end
        check("annul_no_valid", 32'(seen), 32'd0);
        check("annul_q_held", q, 32'hFFFF_FFFF);
        check("annul_r_held", r, 32'd0);

        start = 1'b1; annul = 1'b1; dvd = 32'd9; dvs = 32'd3;
        #1 check("annul_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 start = 1'b0; annul = 1'b0;
        check("annul_start_idle", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1 seen |= valid;
        end
        check("annul_start_no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            annul = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) == 0);
            sop   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: dvd = $urandom;
                1: dvd = $urandom_range(0, 300);
                2: dvd = 32'h8000_0000;
                default: dvd = 32'd0 - $urandom_range(1, 300);
            endcase
            case ($urandom_range(0, 5))
                0: dvs = 32'd0;
                1: dvs = 32'hFFFF_FFFF;
                2: dvs = $urandom_range(1, 20);
                3: dvs = $urandom;
                default: dvs = 32'd0 - $urandom_range(1, 20);
            endcase
        end
        @(posedge clk); #1 start = 1'b0; annul = 1'b1;
        @(posedge clk); #1 annul = 1'b0;

        issue(1'b0, 32'd50, 32'd5);
        wait_res("pre_rst", 33, 32'd10, 32'd0, 1'b0, 0);
        @(posedge clk); #1;
        issue(1'b0, 32'd77, 32'd7);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_q", q, 32'd0);
        check("midrst_r", r, 32'd0);
        check("midrst_dbz", 32'(dbz), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
